// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single registered wide product.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_next;
    logic [2*XLEN-1:0]   acc, mcand;
    logic [XLEN-1:0]     opb, sp_res, res_q;
    logic [2:0]          op_q;
    logic                neg, special, sp_dbz, dbz_q;
    logic [CNT_W-1:0]    cnt;

    logic                sign_a_in, sign_b_in, a_neg_in, b_neg_in, b_zero, ovf, special_in, accept;
    logic [XLEN-1:0]     a_mag_in, b_mag_in, sp_res_in;

    logic [2*XLEN-1:0]   mul_sum, prod, prod_s, div_next;
    logic [XLEN:0]       rem_shift, rem_sub;
    logic                borrow, fast_done, finish;
    logic [XLEN-1:0]     quo, rem, mul_res, div_res, final_res;

    always_comb begin
        sign_a_in  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sign_b_in  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_neg_in   = sign_a_in && src_a[XLEN-1];
        b_neg_in   = sign_b_in && src_b[XLEN-1];
        a_mag_in   = a_neg_in ? -src_a : src_a;
        b_mag_in   = b_neg_in ? -src_b : src_b;
        b_zero     = (src_b == '0);
        ovf        = ((op == 3'd4) || (op == 3'd6)) && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special_in = op[2] && (b_zero || ovf);
        // op[1] distinguishes remainder (REM/REMU) from quotient (DIV/DIVU)
        if (b_zero)
            sp_res_in = op[1] ? src_a : '1;
        else
            sp_res_in = op[1] ? '0 : src_a;
    end

    always_comb begin
        mul_sum   = acc + (opb[0] ? mcand : '0);
`ifdef MULDIV_FAST_MUL_EN
        prod      = mcand * {{XLEN{1'b0}}, opb};
        fast_done = !op_q[2];
`else
        prod      = mul_sum;
        fast_done = 1'b0;
`endif
        prod_s    = neg ? -prod : prod;
        mul_res   = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

        // Remainder lives in acc's upper half; the dividend shifts out of the lower half as quotient bits shift in.
        rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_sub   = rem_shift - {1'b0, opb};
        borrow    = (rem_shift < {1'b0, opb});
        div_next  = {(borrow ? rem_shift[XLEN-1:0] : rem_sub[XLEN-1:0]), acc[XLEN-2:0], ~borrow};
        quo       = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        div_res   = op_q[1] ? (neg ? -rem : rem) : (neg ? -quo : quo);

        final_res = special ? sp_res : (op_q[2] ? div_res : mul_res);
        finish    = special || fast_done || (cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        accept     = in_valid && (state == IDLE);
        unique case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (finish)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0; mcand <= '0; opb <= '0; sp_res <= '0; res_q <= '0;
            op_q <= '0; neg <= 1'b0; special <= 1'b0; sp_dbz <= 1'b0; dbz_q <= 1'b0; cnt <= '0;
        end else if (flush) begin
            res_q <= '0;
            dbz_q <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            op_q    <= op;
            neg     <= (op == 3'd6) ? a_neg_in : (a_neg_in ^ b_neg_in);
            special <= special_in;
            sp_res  <= sp_res_in;
            sp_dbz  <= op[2] && b_zero;
            dbz_q   <= 1'b0;
            opb     <= b_mag_in;
            mcand   <= {{XLEN{1'b0}}, a_mag_in};
            acc     <= op[2] ? {{XLEN{1'b0}}, a_mag_in} : '0;
            cnt     <= CNT_W'(XLEN-1);
        end else if (state == BUSY) begin
            acc   <= op_q[2] ? div_next : mul_sum;
            mcand <= mcand << 1;
            opb   <= op_q[2] ? opb : (opb >> 1);
            cnt   <= cnt - CNT_W'(1);
            if (finish) begin
                res_q <= final_res;
                dbz_q <= special && sp_dbz;
            end
        end
    end

    assign result      = res_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, randomized ops, backpressure, flush and reset abort.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b1;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            in_ready, out_valid, div_by_zero;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        longint      acc_cyc;
        int          lat;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference from RV32M arithmetic rules, using native 64-bit math.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic d, output int lat);
        int          ia, ib;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        ia = int'(a); ib = int'(b);
        sa = longint'(ia); sb = longint'(ib);
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && (o == 3'd4 || o == 3'd6);
        d = 1'b0;
        r = '0;
        case (o)
            3'd0: begin p = 64'(ua * ub); r = p[31:0];  end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
            3'd4: if (b == 0) begin r = '1; d = 1'b1; end else if (ovf) r = a; else r = 32'(ia / ib);
            3'd5: if (b == 0) begin r = '1; d = 1'b1; end else r = a / b;
            3'd6: if (b == 0) begin r = a;  d = 1'b1; end else if (ovf) r = '0; else r = 32'(ia % ib);
            default: if (b == 0) begin r = a; d = 1'b1; end else r = a % b;
        endcase
        lat = XLEN;
        if (o[2] && (b == 0 || ovf)) lat = 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) lat = 1;
`endif
    endfunction

    // Monitor: samples on the falling edge; pops the scoreboard on every handshake.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) chk("unexpected_out_valid", 1, 0);
                else                 chk("latency", cyc - sbq[0].acc_cyc, longint'(sbq[0].lat));
            end
            if (out_valid && out_ready && sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("result", longint'(result), longint'(mon_e.res));
                chk("div_by_zero", longint'(div_by_zero), longint'(mon_e.dbz));
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            op = o; src_a = a; src_b = b; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) begin
                model(o, a, b, e.res, e.dbz, e.lat);
                e.acc_cyc = cyc;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", longint'(sbq.size()), 0);
            sbq.delete();
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1'b1);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          sel, n;

    initial begin
        #3;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_result", longint'(result), 0);
        chk("reset_dbz", longint'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(3'd0, 32'd7, 32'hFFFF_FFFD);
        run(3'd1, 32'h8000_0000, 32'h8000_0000);
        run(3'd2, 32'hFFFF_FFFF, 32'd2);
        run(3'd3, 32'hFFFF_FFFF, 32'd2);
        run(3'd5, 32'd100, 32'd7);
        run(3'd7, 32'd100, 32'd7);
        run(3'd4, 32'hFFFF_FFF9, 32'd2);
        run(3'd6, 32'hFFFF_FFF9, 32'd2);
        run(3'd4, 32'h0000_000A, 32'd0);
        run(3'd6, 32'h0000_000A, 32'd0);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 50; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            sel  = $urandom_range(0, 7);
            if (sel == 0) r_b = '0;
            else if (sel == 1) begin r_a = 32'h8000_0000; r_b = '1; end
            else if (sel == 2) begin r_a = 32'($urandom_range(0, 300)); r_b = 32'($urandom_range(1, 20)); end
            else if (sel == 3) r_b = -32'($urandom_range(1, 20));
            run(r_op, r_a, r_b);
        end

        // Backpressure: the result must hold and new requests must be ignored.
        out_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 1'b1);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_reached_done", longint'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 3'd0; src_a = $urandom; src_b = $urandom;
            @(posedge clk); #1;
            chk("hold_out_valid", longint'(out_valid), 1);
            chk("hold_in_ready", longint'(in_ready), 0);
            chk("hold_result", longint'(result), 14);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", longint'(in_ready), 1);
        chk("release_out_valid", longint'(out_valid), 0);
        drain();

        // Flush during BUSY discards the operation.
        issue(3'd5, 32'd99999, 32'd3, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", longint'(out_valid), 0);
        chk("flush_in_ready", longint'(in_ready), 1);
        chk("flush_result", longint'(result), 0);
        chk("flush_dbz", longint'(div_by_zero), 0);
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_no_late_valid", longint'(out_valid), 0);
        run(3'd5, 32'd9, 32'd3);

        // Asynchronous reset during BUSY.
        run(3'd4, 32'd10, 32'd0);
        issue(3'd4, 32'd12345, 32'd7, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", longint'(out_valid), 0);
        chk("areset_in_ready", longint'(in_ready), 1);
        chk("areset_result", longint'(result), 0);
        chk("areset_dbz", longint'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(3'd5, 32'd9, 32'd3);

        repeat (3) begin @(posedge clk); #1; end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RV32M operation set, companion to the combinational ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake. It computes multiplies with shift-add and divides with restoring division, one bit per cycle, and holds the result until the consumer takes it. Datapath width is a parameter, so the same block serves 32-bit cores and narrower test configurations.

## Interface
- XLEN, 32: operand and result width; legal range 4..64.
- CNT_W, $clog2(XLEN): iteration counter width; derived, not overridden.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; returns the unit to IDLE.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- src_a  in  XLEN  rs1 (multiplicand/dividend).
- src_b  in  XLEN  rs2 (multiplier/divisor).
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result; stable while out_valid=1.
- div_by_zero  out  1  DONE result came from a divisor of zero.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE→BUSY on in_valid&&in_ready.
  - On this edge: latch op; latch |src_a| and |src_b| per signedness; latch result sign; set counter=XLEN-1.
  - Signedness: DIV/REM/MULH sign both operands. MULHSU signs src_a only. MULHU/DIVU/REMU/MUL sign neither; MUL's low half is sign-independent.
- BUSY, multiply:
  - 2*XLEN accumulator; add the shifted multiplicand when the current multiplier bit is 1.
  - MUL returns the low XLEN bits. MULH* return the high XLEN bits after two's-complement negation of the 2*XLEN product if the sign is negative.
- BUSY, divide:
  - Restoring: shift the remainder left by one and bring in the next dividend MSB; subtract the divisor if there is no borrow; the quotient bit is the inverted borrow.
  - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
- BUSY→DONE when counter==0, or early on special cases (evaluated on the accept edge, one BUSY cycle):
  - Divisor==0: quotient all-ones; remainder = src_a unmodified; div_by_zero=1.
  - DIV/REM with src_a=most-negative and src_b=-1: quotient = src_a; remainder = 0.
- DONE→IDLE on out_ready. result and div_by_zero hold until then.
- flush at any state forces IDLE next edge. A pending result is discarded; out_valid falls next edge.
- Reset values: in_ready=1, out_valid=0, result=0, div_by_zero=0, counter=0.

## Timing
- Accept on edge E0. Normal operations reach DONE on edge E(XLEN); out_valid is visible in the cycle after E(XLEN). Latency is XLEN cycles.
- Special-case divides and (with the fast multiplier) multiplies reach DONE on E1: latency 1.
- Result consumed on an edge with out_valid&&out_ready. in_ready rises the same edge. The next operation is accepted no earlier than the following edge, so back-to-back throughput is one op per XLEN+2 cycles.
- out_ready high while not in DONE has no effect. in_valid while BUSY/DONE is ignored; the requester must hold its operands.
- rst_n low mid-operation clears immediately, without waiting for clk. No result is produced for the aborted op.
- flush and out_ready together in DONE: flush wins; the result is not counted as delivered.

## Configuration
- MULDIV_FAST_MUL_EN defined: multiplies use a single registered 2*XLEN product computed combinationally from the latched operands. They reach DONE on E1 (latency 1). Divides are unchanged.
- MULDIV_FAST_MUL_EN undefined: multiplies iterate XLEN cycles as above. No wide multiplier is instantiated.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32) → result 0xFFFFFFEB, out_valid 32 cycles after accept (1 with MULDIV_FAST_MUL_EN).
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF. MULHU 0xFFFFFFFF × 2 → 0x00000001.
- DIVU 100/7 → 14, REMU → 2. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. Each has latency 32.
- DIV 0x0000000A/0 → 0xFFFFFFFF, div_by_zero=1, latency 1. REM same operands → 0x0000000A. DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, div_by_zero=0.
- Hold out_ready=0 for 10 cycles in DONE → result and out_valid stable, in_ready=0, in_valid ignored. Release → IDLE next edge.
- Assert rst_n=0 and, separately, flush=1 at BUSY cycle 10 → outputs at reset values. A subsequent DIVU 9/3 returns 3 with no corruption.
